// File: rtl/corelet_ctrl.sv
// corelet_ctrl: weight-stationary tap sequencer for the corelet.
// For every kernel tap it fetches weights into L0, loads them into the MAC
// array, lets them settle, fetches activations, executes, and drains the
// OFIFO through the SFP accumulators. All outputs are registered.
module corelet_ctrl #(
   parameter int                ROW      = 8,
   parameter int                COL      = 8,
   parameter int                ADDR_W   = 11,
   parameter int                TAP_W    = 4,
   parameter int                LEN_W    = 7,
   parameter logic [ADDR_W-1:0] ACT_BASE = 11'd1024
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [TAP_W-1:0]  i_num_tap,
   input  logic [LEN_W-1:0]  i_num_act,
   input  logic              i_l0_full,
   input  logic              i_ofifo_valid,
   output logic              o_sram_cen,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [34:0]       o_inst,
   output logic              o_busy,
   output logic              o_done
);

   // One spare bit so a fetch counter can reach num_act itself.
   localparam int CNT_W = LEN_W + 1;

   localparam logic [1:0] MAC_LOAD = 2'b01;
   localparam logic [1:0] MAC_EXEC = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_W_FETCH, S_W_LOAD, S_W_SETTLE, S_A_FETCH, S_EXEC, S_DRAIN, S_DONE
   } state_t;

   state_t            r_state;
   logic [TAP_W-1:0]  r_num_tap;
   logic [LEN_W-1:0]  r_num_act;
   logic [TAP_W-1:0]  r_t;
   logic [CNT_W-1:0]  r_cnt;

   logic [ADDR_W-1:0] w_fetch_base;
   logic [CNT_W-1:0]  w_fetch_len;
   logic [CNT_W-1:0]  w_act_last;
   logic              w_more_taps;

   // Weight words of tap t live at t*COL (wrapping at ADDR_W bits); activations at ACT_BASE.
   assign w_fetch_base = (r_state == S_W_FETCH) ? ADDR_W'(r_t) * ADDR_W'(COL) : ACT_BASE;
   assign w_fetch_len  = (r_state == S_W_FETCH) ? CNT_W'(COL) : CNT_W'(r_num_act);
   assign w_act_last   = CNT_W'(r_num_act) - CNT_W'(1);
   assign w_more_taps  = ({1'b0, r_t} + (TAP_W+1)'(1)) < {1'b0, r_num_tap};

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_num_tap   <= '0;
         r_num_act   <= '0;
         r_t         <= '0;
         r_cnt       <= '0;
         o_sram_cen  <= 1'b1;
         o_sram_addr <= '0;
         o_inst      <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_done     <= 1'b0;
         o_sram_cen <= 1'b1;
         o_inst     <= '0;
         case (r_state)
            S_IDLE: begin
               // A start in the cycle done is still visible belongs to the finished job.
               if (i_start && !o_done) begin
                  r_num_tap <= i_num_tap;
                  r_num_act <= i_num_act;
                  r_t       <= '0;
                  r_cnt     <= '0;
                  o_busy    <= 1'b1;
                  if (i_num_tap == '0 || i_num_act == '0)
                     r_state <= S_DONE;
                  else
                     r_state <= S_W_FETCH;
               end
            end
            S_W_FETCH, S_A_FETCH: begin
               // Read data returns one cycle later, so the L0 write trails the issued read.
               o_inst[2] <= ~o_sram_cen;
               if (r_cnt == w_fetch_len) begin
                  // Last read was issued on the previous edge; its write goes out now.
                  r_cnt   <= '0;
                  r_state <= (r_state == S_W_FETCH) ? S_W_LOAD : S_EXEC;
               end else if (!i_l0_full) begin
                  o_sram_cen  <= 1'b0;
                  o_sram_addr <= w_fetch_base + ADDR_W'(r_cnt);
                  r_cnt       <= r_cnt + CNT_W'(1);
               end
            end
            S_W_LOAD: begin
               o_inst[3]   <= 1'b1;
               o_inst[1:0] <= MAC_LOAD;
               if (r_cnt == CNT_W'(COL - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_W_SETTLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_W_SETTLE: begin
               if (r_cnt == CNT_W'(ROW + COL - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_A_FETCH;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_EXEC: begin
               o_inst[3]   <= 1'b1;
               o_inst[1:0] <= MAC_EXEC;
               if (r_cnt == w_act_last) begin
                  r_cnt   <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (i_ofifo_valid) begin
                  o_inst[6]  <= 1'b1;
                  o_inst[33] <= 1'b1;
                  if (r_cnt == w_act_last) begin
                     r_cnt <= '0;
                     if (w_more_taps) begin
                        r_t     <= r_t + TAP_W'(1);
                        r_state <= S_W_FETCH;
                     end else begin
                        r_state <= S_DONE;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: walks the expected phase sequence of each job cycle by
// cycle, deriving addresses, instruction words and phase lengths from the
// stimulus it drives, and compares the sequencer outputs against them.
`timescale 1ns/1ps
module tb_corelet_ctrl;

   localparam int ROW      = 8;
   localparam int COL      = 8;
   localparam int ACT_BASE = 1024;
   localparam int AMOD     = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  num_tap = '0;
   logic [6:0]  num_act = '0;
   logic        l0_full = 1'b0;
   logic        ofifo_valid = 1'b0;
   logic        sram_cen;
   logic [10:0] sram_addr;
   logic [34:0] inst;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;
   int done_cnt = 0;
   bit noise = 1'b0;

   corelet_ctrl dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_num_tap     (num_tap),
      .i_num_act     (num_act),
      .i_l0_full     (l0_full),
      .i_ofifo_valid (ofifo_valid),
      .o_sram_cen    (sram_cen),
      .o_sram_addr   (sram_addr),
      .o_inst        (inst),
      .o_busy        (busy),
      .o_done        (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   task automatic drive_noise();
      if (noise) begin
         l0_full     = 1'($urandom_range(0, 1));
         ofifo_valid = 1'($urandom_range(0, 1));
      end else begin
         l0_full     = 1'b0;
         ofifo_valid = 1'b0;
      end
   endtask

   // Fetch: one read per cycle while L0 has room, each followed a cycle later by an L0 write.
   task automatic fetch_phase(input string tag, input int base, input int n, input int mode, output int len);
      int issued = 0;
      int writes = 0;
      int idx = 0;
      bit pend = 1'b0;
      bit last;
      bit full;
      bit iss;
      bit finished = 1'b0;
      while (!finished && idx < 1000) begin
         drive_noise();
         case (mode)
            0:       full = 1'b0;
            1:       full = ($urandom_range(0, 3) == 0);
            default: full = (idx >= 3 && idx <= 5);
         endcase
         l0_full = full;
         last = (issued == n);
         iss  = !last && !full;
         step();
         idx++;
         check_val({tag, "_cen"}, sram_cen, !iss);
         if (iss) check_val({tag, "_addr"}, sram_addr, (base + issued) % AMOD);
         check_val({tag, "_inst"}, inst, pend ? 64'h4 : 64'h0);
         if (inst[2]) writes++;
         pend = iss;
         if (iss) issued++;
         if (last) finished = 1'b1;
      end
      check_val({tag, "_end"}, finished, 1);
      check_val({tag, "_writes"}, writes, n);
      len = idx;
   endtask

   task automatic const_phase(input string tag, input int n, input logic [34:0] exp);
      for (int i = 0; i < n; i++) begin
         drive_noise();
         step();
         check_val(tag, inst, exp);
         check_val({tag, "_cen"}, sram_cen, 1);
      end
   endtask

   task automatic exec_phase(input int n, input int abort_at, output bit aborted);
      aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
         drive_noise();
         step();
         check_val("exec_inst", inst, 64'hA);
         if (i + 1 == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_val("rst_inst", inst, 0);
            check_val("rst_cen", sram_cen, 1);
            check_val("rst_busy", busy, 0);
            check_val("rst_done", done, 0);
            aborted = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain_phase(input int n, input int mode, output int len);
      logic [6:0] pat;
      int reads = 0;
      int idx = 0;
      bit v;
      pat = 7'b1011001;
      while (reads < n && idx < 1000) begin
         drive_noise();
         case (mode)
            0:       v = 1'b1;
            1:       v = ($urandom_range(0, 9) < 7);
            default: v = (idx < 7) ? pat[idx] : 1'b1;
         endcase
         ofifo_valid = v;
         step();
         idx++;
         check_val("drain_inst", inst, v ? ((64'h1 << 33) | 64'h40) : 64'h0);
         if (inst[6]) reads++;
      end
      check_val("drain_reads", reads, n);
      ofifo_valid = 1'b0;
      len = idx;
   endtask

   task automatic run_job(input int ntap, input int nact, input int fmode, input int vmode,
                          input int abort_at, input bit sid, output int total);
      int len;
      int d0;
      bit aborted = 1'b0;
      d0 = done_cnt;
      num_tap = 4'(ntap);
      num_act = 7'(nact);
      start   = 1'b1;
      step();
      cyc_cnt = 0;
      start   = 1'b0;
      check_val("start_busy", busy, 1);
      check_val("start_inst", inst, 0);
      check_val("start_cen", sram_cen, 1);
      check_val("start_done", done, 0);
      if (ntap == 0 || nact == 0) begin
         if (sid) begin
            start = 1'b1;
            num_tap = 4'd2;
            num_act = 7'd3;
         end
      end else begin
         for (int t = 0; t < ntap && !aborted; t++) begin
            fetch_phase("wfetch", t * COL, COL, (t == 0) ? fmode : ((fmode == 2) ? 0 : fmode), len);
            if (fmode == 2 && t == 0) check_val("wfetch_len", len, COL + 1 + 3);
            const_phase("wload", COL, 35'h9);
            const_phase("settle", ROW + COL, 35'h0);
            fetch_phase("afetch", ACT_BASE, nact, (fmode == 2) ? 0 : fmode, len);
            exec_phase(nact, (t == 0) ? abort_at : 0, aborted);
            if (!aborted) begin
               drain_phase(nact, vmode, len);
               if (vmode == 2) check_val("drain_len", len, 7);
            end
         end
      end
      if (aborted) begin
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         for (int i = 0; i < 20; i++) begin
            drive_noise();
            step();
            check_val("post_rst_busy", busy, 0);
            check_val("post_rst_done", done, 0);
            check_val("post_rst_cen", sram_cen, 1);
            check_val("post_rst_inst", inst, 0);
         end
         check_val("abort_done_pulses", done_cnt - d0, 0);
         total = -1;
      end else begin
         drive_noise();
         step();
         total = cyc_cnt;
         check_val("done_pulse", done, 1);
         check_val("done_busy", busy, 0);
         check_val("done_inst", inst, 0);
         check_val("done_cen", sram_cen, 1);
         if (sid) begin
            start = 1'b1;
            num_tap = 4'd2;
            num_act = 7'd3;
         end
         step();
         start = 1'b0;
         check_val("after_done", done, 0);
         check_val("after_busy", busy, 0);
         step();
         check_val("idle_busy", busy, 0);
         check_val("idle_cen", sram_cen, 1);
         check_val("done_pulses", done_cnt - d0, 1);
      end
      $display("job taps=%0d acts=%0d cycles=%0d", ntap, nact, total);
   endtask

   initial begin
      int tot;
      int nt;
      int na;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_inst", inst, 0);
      check_val("reset_cen", sram_cen, 1);
      check_val("reset_addr", sram_addr, 0);
      check_val("reset_busy", busy, 0);
      check_val("reset_done", done, 0);
      rst_n = 1'b1;
      step();
      check_val("idle_no_start", busy, 0);

      noise = 1'b0;
      run_job(1, 4, 0, 0, 0, 1'b0, tot);
      check_val("single_tap_done_cycle", tot, 1 + 9 + 8 + 16 + 5 + 4 + 4);
      run_job(3, 2, 0, 0, 0, 1'b0, tot);
      check_val("three_tap_done_cycle", tot, 1 + 3 * (9 + 8 + 16 + 3 + 2 + 2));
      run_job(1, 3, 2, 0, 0, 1'b0, tot);
      check_val("stall_done_cycle", tot, 1 + 12 + 8 + 16 + 4 + 3 + 3);
      run_job(1, 4, 0, 2, 0, 1'b0, tot);
      check_val("drain_gap_done_cycle", tot, 1 + 9 + 8 + 16 + 5 + 4 + 7);
      run_job(2, 0, 0, 0, 0, 1'b1, tot);
      check_val("zero_act_done_cycle", tot, 1);
      run_job(0, 5, 0, 0, 0, 1'b1, tot);
      check_val("zero_tap_done_cycle", tot, 1);
      run_job(2, 4, 0, 0, 2, 1'b0, tot);

      noise = 1'b1;
      for (int j = 0; j < 12; j++) begin
         nt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
         na = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
         run_job(nt, na, 1, 1, 0, 1'($urandom_range(0, 1)), tot);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Weight-stationary sequencer for the corelet. It drives the corelet's 35-bit instruction word and a shared activation/weight SRAM read port. For each kernel tap it runs five phases: fetch the weights into L0, load them into the MAC array, fetch the activations into L0, execute, and drain the OFIFO through the SFP accumulators. It sits between the top-level testbench/host (start/done) and the corelet.

## Interface
- row, 8, MAC array rows (L0 lanes)
- col, 8, MAC array columns; weight words per tap
- addr_w, 11, SRAM address width
- tap_w, 4, width of tap count
- len_w, 7, width of activation count
- ACT_BASE, 11'd1024, first activation word address; weights start at address 0
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  one-cycle request; sampled only in IDLE
- num_tap  in  tap_w  kernel taps to run; latched on accepted start
- num_act  in  len_w  activation vectors per tap; latched on accepted start
- l0_full  in  1  L0 back-pressure; high means at most one free entry remains
- ofifo_valid  in  1  OFIFO holds a complete output row
- sram_cen  out  1  SRAM chip enable, active-low
- sram_addr  out  addr_w  SRAM read address
- inst  out  35  corelet instruction: [1:0] mac inst (01 kernel load, 10 execute), [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] sfp acc, [34] mode (fixed 0 = WS); all other bits 0
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle completion pulse

## Operation
- All outputs are registered.
- Reset values: inst=0, sram_cen=1, sram_addr=0, busy=0, done=0, state IDLE, all counters 0.
- FSM states: IDLE, W_FETCH, W_LOAD, W_SETTLE, A_FETCH, EXEC, DRAIN, DONE.
- IDLE: start=1 latches num_tap/num_act, clears tap counter t, and enters W_FETCH.
  - If the latched num_tap or num_act is 0, the FSM goes to DONE instead and issues no SRAM or inst activity.
- W_FETCH: issues col reads at addresses t*col + k, k=0..col-1.
  - A read is issued (sram_cen=0) only in cycles where l0_full=0.
  - SRAM latency is 1, so l0_wr is asserted the cycle after each issued read. An in-flight write always completes, even if l0_full rises.
  - Exit when col writes are done.
- W_LOAD: inst[3]=1 and inst[1:0]=01 for col cycles.
- W_SETTLE: inst=0 for row+col cycles so the weights propagate through the array.
- A_FETCH: identical to W_FETCH, except num_act reads at addresses ACT_BASE + a.
- EXEC: inst[3]=1 and inst[1:0]=10 for num_act cycles.
- DRAIN: in each cycle with ofifo_valid=1, asserts inst[6]=1 and inst[33]=1 and counts one row.
  - After num_act rows: if t+1 < num_tap, increment t and go to W_FETCH; otherwise go to DONE.
- DONE: done=1 for exactly one cycle, busy drops, return to IDLE.
- Address arithmetic: t*col + k is computed at addr_w bits and wraps modulo 2^addr_w. No overflow check is performed.
- start outside IDLE is ignored, including start in the DONE cycle.
- Reset mid-operation: outputs go to their reset values immediately (asynchronously). Latched counts are discarded, and no done pulse is emitted.

## Timing
- An accepted start at edge 0 puts the first weight address on sram_addr after edge 1.
- The matching l0_wr follows after edge 2.
- Stall-free per-tap cycles:
  - W_FETCH: col+1
  - W_LOAD: col
  - W_SETTLE: row+col
  - A_FETCH: num_act+1
  - EXEC: num_act
  - DRAIN: num_act plus any cycles where ofifo_valid=0
- l0_full stalls extend only the fetch phases, by one cycle per stalled cycle.
- done asserts the cycle after the last ofifo_rd of the final tap. busy falls in the same cycle done is high.
- inst[3] and inst[1:0] change together on the same edge. There is never a cycle with l0_rd=1 and mac inst=00.

## Test plan
- Reset low mid-EXEC with num_tap=2, num_act=4 -> inst=0 and sram_cen=1 immediately; after release, the FSM stays in IDLE and done never pulses.
- Single tap, num_act=4, ofifo_valid held 1, l0_full=0 -> addresses 0..7 then 1024..1027.
  - 8 l0_wr, 8 kernel-load cycles, 16 settle cycles, 4 l0_wr, 4 execute cycles, 4 ofifo_rd with acc=1.
  - done exactly once at cycle 1+9+8+16+5+4+4.
- num_tap=3, num_act=2 -> weight bases 0, 8, 16 in order; 3 DRAIN phases; one done pulse at the end.
- l0_full=1 for 3 cycles in the middle of W_FETCH -> no sram_cen=0 in those cycles, the in-flight word is still written, exactly 8 weight writes total, and the phase is 3 cycles longer.
- ofifo_valid toggling 1,0,0,1,1,0,1 in DRAIN with num_act=4 -> ofifo_rd asserted only in the valid cycles; exits after the 4th read.
- num_act=0, start=1 -> done two cycles later; no sram_cen=0, inst stays 0; a start pulse during DONE is ignored.
